// File: rtl/lsu_pkg.sv
// Shared types for the data-memory access unit: FSM states, decoded access kinds
// and the word geometry used by the byte-lane logic.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_LW,
    OP_LBU,
    OP_SB,
    OP_SW
  } op_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/response bus between the access unit (master) and data memory (slave).
interface dmem_access_unit_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_addr,
    output mem_we,
    output mem_wstrb,
    output mem_wdata,
    input  mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_addr,
    input  mem_we,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_rsp_valid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: store strobes and lane replication, and
// load byte extraction with zero-extension.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [WORD_BYTES-1:0] lane_sel;
  logic [31:0]           store_repl;
  logic [7:0]            lane_byte [WORD_BYTES];
  logic [7:0]            load_byte;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign lane_sel[gi]          = (byte_off == 2'(gi));
      assign store_repl[8*gi +: 8] = store_data[7:0];
      assign lane_byte[gi]         = rdata[8*gi +: 8];
    end
  endgenerate

  assign load_byte = lane_byte[byte_off];

  always_comb begin
    wstrb     = '0;
    wdata     = '0;
    load_data = rdata;
    case (op)
      OP_SW: begin
        wstrb = 4'hF;
        wdata = store_data;
      end
      OP_SB: begin
        wstrb = lane_sel;
        wdata = store_repl;
      end
      OP_LBU: load_data = {24'b0, load_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns one decoded lw/lbu/sb/sw into a single
// outstanding valid/ready request, stalls the core and reports the outcome.
module dmem_access_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lw_enable,
  input  logic                     lbu_enable,
  input  logic                     sb_enable,
  input  logic                     sw_enable,
  input  logic [31:0]              address,
  input  logic [31:0]              store_data,
  input  logic [4:0]               rd,
  output logic                     stall,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     store_done,
  output logic                     misalign_err,
  output logic                     bus_err,
  dmem_access_unit_if.master       mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_reg, state_next;
  op_e              op_reg;
  logic [1:0]       byte_off_reg;
  logic [4:0]       rd_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             req_valid_reg;
  logic [31:0]      maddr_reg;
  logic             we_reg;
  logic [3:0]       wstrb_reg;
  logic [31:0]      wdata_reg;
  logic             wb_valid_reg;
  logic [4:0]       wb_rd_reg;
  logic [31:0]      wb_data_reg;
  logic             store_done_reg;
  logic             misalign_reg;
  logic             bus_err_reg;

  logic [3:0]       en;
  logic             op_present;
  logic             exactly_one;
  logic             misaligned;
  op_e              dec_op;

  op_e              lane_op;
  logic [1:0]       lane_off;
  logic [3:0]       lane_wstrb;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_load;

  assign en          = {sw_enable, sb_enable, lbu_enable, lw_enable};
  assign op_present  = |en;
  assign exactly_one = op_present && ((en & (en - 4'd1)) == 4'd0);
  assign misaligned  = (lw_enable || sw_enable) && (address[1:0] != 2'b00);

  always_comb begin
    if (sw_enable)       dec_op = OP_SW;
    else if (sb_enable)  dec_op = OP_SB;
    else if (lbu_enable) dec_op = OP_LBU;
    else                 dec_op = OP_LW;
  end

  // The lane steering serves the incoming op while idle (store strobes/data are
  // registered at capture) and the captured op afterwards (load extraction).
  assign lane_op  = (state_reg == S_IDLE) ? dec_op : op_reg;
  assign lane_off = (state_reg == S_IDLE) ? address[1:0] : byte_off_reg;

  lsu_byte_lane u_byte_lane (
    .op         (lane_op),
    .byte_off   (lane_off),
    .store_data (store_data),
    .rdata      (mem.mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (op_present) state_next = (exactly_one && !misaligned) ? S_REQ : S_DONE;
      S_REQ:  if (mem.mem_req_ready) state_next = S_WAIT;
      S_WAIT: if (mem.mem_rsp_valid || (cnt_reg == CNT_LAST)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_reg)
      S_IDLE:  stall = op_present;
      S_REQ:   stall = 1'b1;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      op_reg         <= OP_LW;
      byte_off_reg   <= '0;
      rd_reg         <= '0;
      cnt_reg        <= '0;
      req_valid_reg  <= 1'b0;
      maddr_reg      <= '0;
      we_reg         <= 1'b0;
      wstrb_reg      <= '0;
      wdata_reg      <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      store_done_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wb_valid_reg   <= 1'b0;
      store_done_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      bus_err_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (op_present) begin
            if (!exactly_one) begin
              bus_err_reg <= 1'b1;
            end else if (misaligned) begin
              misalign_reg <= 1'b1;
            end else begin
              op_reg        <= dec_op;
              byte_off_reg  <= address[1:0];
              rd_reg        <= rd;
              req_valid_reg <= 1'b1;
              maddr_reg     <= {address[31:2], 2'b00};
              we_reg        <= is_store(dec_op);
              wstrb_reg     <= lane_wstrb;
              wdata_reg     <= lane_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready) begin
            req_valid_reg <= 1'b0;
            we_reg        <= 1'b0;
            wstrb_reg     <= '0;
            cnt_reg       <= '0;
          end
        end
        S_WAIT: begin
          // A response arriving on the final timeout cycle still completes normally.
          if (mem.mem_rsp_valid) begin
            if (is_store(op_reg)) begin
              store_done_reg <= 1'b1;
            end else begin
              wb_valid_reg <= (rd_reg != 5'd0);
              wb_rd_reg    <= rd_reg;
              wb_data_reg  <= lane_load;
            end
          end else if (cnt_reg == CNT_LAST) begin
            bus_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req_valid = req_valid_reg;
  assign mem.mem_addr      = maddr_reg;
  assign mem.mem_we        = we_reg;
  assign mem.mem_wstrb     = wstrb_reg;
  assign mem.mem_wdata     = wdata_reg;

  assign wb_valid     = wb_valid_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;
  assign store_done   = store_done_reg;
  assign misalign_err = misalign_reg;
  assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: zero-wait loads, lane handling, held
// requests, misalignment, illegal op mix, timeout and reset abandonment.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lw_enable, lbu_enable, sb_enable, sw_enable;
  logic [31:0] address, store_data;
  logic [4:0]  rd;
  logic        stall, wb_valid, store_done, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lw_enable    (lw_enable),
    .lbu_enable   (lbu_enable),
    .sb_enable    (sb_enable),
    .sw_enable    (sw_enable),
    .address      (address),
    .store_data   (store_data),
    .rd           (rd),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .store_done   (store_done),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .mem          (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    lw_enable  = 1'b0;
    lbu_enable = 1'b0;
    sb_enable  = 1'b0;
    sw_enable  = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input logic [3:0] exp_pulses);
    $display("[TB] %s: wb_valid=%0b store_done=%0b misalign=%0b bus_err=%0b",
             tag, wb_valid, store_done, misalign_err, bus_err);
    chk({tag, "_pulses"}, 32'({wb_valid, store_done, misalign_err, bus_err}), 32'(exp_pulses));
  endtask

  initial begin
    rst_n               = 1'b0;
    clear_ops();
    address             = '0;
    store_data          = '0;
    rd                  = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rsp_valid   = 1'b0;
    bus.mem_rdata       = '0;

    // Reset / idle
    step();
    step();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_bus", {bus.mem_addr[31:6], 1'b0, bus.mem_we, bus.mem_wstrb}, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_wb", {22'b0, wb_rd, wb_valid, store_done, misalign_err, bus_err}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    $display("[TB] reset: stall=%0b req_valid=%0b", stall, bus.mem_req_valid);
    rst_n = 1'b1;
    step();

    // lw 0x100, zero-wait, rd=5
    lw_enable = 1'b1; address = 32'h100; rd = 5'd5;
    #1;
    chk("lw_t0_stall", 32'(stall), 32'h1);
    chk("lw_t0_no_req", 32'(bus.mem_req_valid), 32'h0);
    step();
    chk("lw_t1_req", 32'(bus.mem_req_valid), 32'h1);
    chk("lw_t1_addr", bus.mem_addr, 32'h100);
    chk("lw_t1_we_strb", 32'({bus.mem_we, bus.mem_wstrb}), 32'h0);
    chk("lw_t1_stall", 32'(stall), 32'h1);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("lw_t2_req_low", 32'(bus.mem_req_valid), 32'h0);
    chk("lw_t2_stall", 32'(stall), 32'h1);
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_outcome("lw", 4'b1000);
    chk("lw_wb_rd", 32'(wb_rd), 32'd5);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_t3_stall", 32'(stall), 32'h0);
    clear_ops();
    step();
    chk("lw_t4_pulse_gone", 32'({wb_valid, stall, bus.mem_req_valid}), 32'h0);

    // lbu 0x103 -> top byte
    lbu_enable = 1'b1; address = 32'h103; rd = 5'd7;
    step();
    chk("lbu_addr_aligned", bus.mem_addr, 32'h100);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hAABBCCDD;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_outcome("lbu", 4'b1000);
    chk("lbu_wb_data", wb_data, 32'h000000AA);
    chk("lbu_wb_rd", 32'(wb_rd), 32'd7);
    clear_ops();
    step();

    // sb 0x202 with ready held low for 3 cycles; stray rsp during REQ ignored
    sb_enable = 1'b1; address = 32'h202; store_data = 32'h1234565A; rd = 5'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sb_req_held", 32'(bus.mem_req_valid), 32'h1);
      chk("sb_addr", bus.mem_addr, 32'h200);
      chk("sb_we_strb", 32'({bus.mem_we, bus.mem_wstrb}), 32'h14);
      chk("sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
      chk("sb_no_done", 32'(store_done), 32'h0);
      bus.mem_rsp_valid = (i == 1);
      bus.mem_req_ready = (i == 3);
    end
    step();
    bus.mem_req_ready = 1'b0;
    chk("sb_wait_req_low", 32'(bus.mem_req_valid), 32'h0);
    chk("sb_wait_stall", 32'(stall), 32'h1);
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_outcome("sb", 4'b0100);
    clear_ops();
    step();
    chk("sb_done_once", 32'(store_done), 32'h0);

    // sw misaligned 0x101
    sw_enable = 1'b1; address = 32'h101; store_data = 32'hCAFEF00D;
    #1;
    chk("sw_mis_t0_stall", 32'(stall), 32'h1);
    step();
    check_outcome("sw_mis", 4'b0010);
    chk("sw_mis_no_req", 32'(bus.mem_req_valid), 32'h0);
    chk("sw_mis_t1_stall", 32'(stall), 32'h0);
    clear_ops();
    step();
    chk("sw_mis_gone", 32'({misalign_err, stall, bus.mem_req_valid}), 32'h0);

    // Illegal mix: lw + sb together
    lw_enable = 1'b1; sb_enable = 1'b1; address = 32'h400;
    step();
    check_outcome("mix", 4'b0001);
    chk("mix_no_req", 32'(bus.mem_req_valid), 32'h0);
    clear_ops();
    step();

    // lw to x0: write-back suppressed
    lw_enable = 1'b1; address = 32'h104; rd = 5'd0;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h11111111;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_outcome("lw_x0", 4'b0000);
    chk("lw_x0_stall", 32'(stall), 32'h0);
    clear_ops();
    step();

    // Timeout: no response for 64 WAIT cycles
    lw_enable = 1'b1; address = 32'h300; rd = 5'd3;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    repeat (63) step();
    chk("to_not_yet", 32'({bus_err, stall}), 32'h1);
    step();
    check_outcome("timeout", 4'b0001);
    chk("to_stall", 32'(stall), 32'h0);
    clear_ops();
    step();

    // Response on the last timeout cycle wins
    lw_enable = 1'b1; address = 32'h308; rd = 5'd9;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    repeat (63) step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_outcome("late_rsp", 4'b1000);
    chk("late_rsp_data", wb_data, 32'h0BADF00D);
    clear_ops();
    step();

    // Reset during WAIT abandons the access; later response ignored
    lw_enable = 1'b1; address = 32'h500; rd = 5'd4;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    clear_ops();
    step();
    chk("rstw_req_low", 32'(bus.mem_req_valid), 32'h0);
    chk("rstw_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_rsp_valid = 1'b0;
    step();
    check_outcome("rst_wait", 4'b0000);
    chk("rstw_wb_data", wb_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
